wb_master_bridge: RTL and testbench

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge_pkg.sv | 27 ++
 rtl/wb_master_bridge_if.sv | 28 ++
 rtl/wb_master_bridge.sv | 117 +++++++++++
 tb/tb_wb_master_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_bridge_pkg
//   Shared definitions for the command-to-Wishbone bridge:
//   - state_t         : FSM state encoding (IDLE=0, BUS=1, RESP=2)
//   - DEFAULT_TIMEOUT : default number of wait cycles before a bus abort
//   - cmd_t           : one latched command (direction, address, data, lanes)
// -----------------------------------------------------------------------------
package wb_master_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_TIMEOUT = 8'd255;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, sel: 4'h0};

endpackage : wb_master_bridge_pkg

// File: rtl/wb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_master_bridge_if
//   Wishbone classic single-master bus bundle.
//   master modport : drives cyc/stb/we/adr/dat_o/sel, receives dat_i/ack
//   slave  modport : the mirror view, used by a slave model or interconnect
// -----------------------------------------------------------------------------
interface wb_master_bridge_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface : wb_master_bridge_if

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//   Turns a valid/ready command stream into single Wishbone classic cycles and
//   returns one valid/ready response per command. One transaction in flight.
//
//   Parameters
//     TIMEOUT   : cycles the strobe may wait for ack; the strobe is held for
//                 TIMEOUT+1 cycles before the cycle is aborted with rsp_err.
//   Ports
//     clk, resetn            : clock, asynchronous active-low reset
//     cmd_valid/cmd_ready    : command handshake (cmd_ready high only in IDLE)
//     cmd_we/addr/wdata/sel  : command payload, sampled on the handshake
//     rsp_valid/rsp_ready    : response handshake
//     rsp_rdata, rsp_err     : read data (0 for writes/errors), timeout flag
//     wb                     : Wishbone master port
// -----------------------------------------------------------------------------
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,

  wb_master_bridge_if.master wb
);

  state_t      state;
  cmd_t        bus_q;       // command driven on the bus, held for the whole cycle
  logic        bus_active;  // drives both cyc and stb (classic, no bursts)
  logic [7:0]  wait_cnt;

  // Decoded from state alone so the ready never depends on cmd_valid.
  assign cmd_ready = (state == ST_IDLE);

  assign wb.wbm_cyc_o = bus_active;
  assign wb.wbm_stb_o = bus_active;
  assign wb.wbm_we_o  = bus_q.we;
  assign wb.wbm_adr_o = bus_q.addr;
  assign wb.wbm_dat_o = bus_q.wdata;
  assign wb.wbm_sel_o = bus_q.sel;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      bus_q      <= CMD_IDLE;
      bus_active <= 1'b0;
      wait_cnt   <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            bus_q      <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, sel: cmd_sel};
            bus_active <= 1'b1;
            wait_cnt   <= 8'd0;
            state      <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Ack is checked first so an ack on the final wait cycle still
          // completes the transfer rather than reporting a timeout.
          if (wb.wbm_ack_i) begin
            bus_active <= 1'b0;
            bus_q.we   <= 1'b0;
            rsp_rdata  <= bus_q.we ? 32'h0 : wb.wbm_dat_i;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (wait_cnt == TIMEOUT) begin
            bus_active <= 1'b0;
            bus_q.we   <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          // Returning to IDLE only here means a command offered during the
          // response handshake is taken on the following cycle at the earliest.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          bus_active <= 1'b0;
          rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule : wb_master_bridge

// File: tb/tb_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bridge
//   Directed bench for wb_master_bridge with TIMEOUT=10. The Wishbone slave is
//   played directly by the stimulus (ack/dat_i driven on the falling edge).
//   Outputs are sampled on the falling edge, half a cycle after each update.
// -----------------------------------------------------------------------------
module tb_wb_master_bridge;

  localparam logic [7:0] TMO = 8'd10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  wb_master_bridge_if wb ();

  wb_master_bridge #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb        (wb.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Offers a command on a falling edge; returns on the falling edge of the
  // first BUS cycle with cmd_valid dropped again.
  task automatic send_cmd(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
    @(negedge clk);
    check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", {31'h0, rsp_valid}, 32'h0);
    check("cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    int n;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb.wbm_stb_o}, 32'h0);
    check("rst_adr", wb.wbm_adr_o, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    resetn = 1'b1;

    // Stray ack in IDLE does nothing
    wb.wbm_ack_i = 1'b1;
    @(negedge clk);
    wb.wbm_ack_i = 1'b0;
    check("idle_ack_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("idle_ack_rsp", {31'h0, rsp_valid}, 32'h0);

    // Write, slave acks one cycle after stb
    send_cmd(1'b1, 32'h2100_0004, 32'h0000_0001, 4'hF);
    for (int i = 0; i < 2; i++) begin
      check("wr_cyc", {31'h0, wb.wbm_cyc_o}, 32'h1);
      check("wr_stb", {31'h0, wb.wbm_stb_o}, 32'h1);
      check("wr_we", {31'h0, wb.wbm_we_o}, 32'h1);
      check("wr_adr", wb.wbm_adr_o, 32'h2100_0004);
      check("wr_dat", wb.wbm_dat_o, 32'h0000_0001);
      check("wr_sel", {28'h0, wb.wbm_sel_o}, 32'hF);
      check("wr_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      if (i == 1) begin
        wb.wbm_ack_i = 1'b1;
        wb.wbm_dat_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    wb.wbm_ack_i = 1'b0;
    check("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_cyc_drop", {31'h0, wb.wbm_cyc_o}, 32'h0);
    rsp_handshake();

    // Zero-wait read; cmd inputs wiggled while busy must be ignored
    send_cmd(1'b0, 32'h2100_0000, 32'h0, 4'hF);
    check("rd_we", {31'h0, wb.wbm_we_o}, 32'h0);
    check("rd_adr", wb.wbm_adr_o, 32'h2100_0000);
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h0000_0003;
    cmd_addr     = 32'hBAD0_0000;
    cmd_we       = 1'b1;
    @(negedge clk);
    wb.wbm_ack_i = 1'b0;
    check("rd_latency_valid", {31'h0, rsp_valid}, 32'h1);
    check("rd_rdata", rsp_rdata, 32'h0000_0003);
    check("rd_err", {31'h0, rsp_err}, 32'h0);
    check("rd_adr_held", wb.wbm_adr_o, 32'h2100_0000);
    rsp_handshake();

    // Read with no ack: strobe held TIMEOUT+1 cycles, then error
    wb.wbm_dat_i = 32'hDEAD_BEEF;
    send_cmd(1'b0, 32'h2200_0000, 32'h0, 4'hF);
    n = 0;
    while (wb.wbm_stb_o && n < 300) begin
      check("tmo_we_low", {31'h0, wb.wbm_we_o}, 32'h0);
      n++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", n, 32'd11);
    check("tmo_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("tmo_rsp_err", {31'h0, rsp_err}, 32'h1);
    check("tmo_rsp_rdata", rsp_rdata, 32'h0);
    check("tmo_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    rsp_handshake();

    // Ack on the cycle where the counter equals TIMEOUT: ack wins
    send_cmd(1'b0, 32'h2300_0010, 32'h0, 4'h3);
    repeat (10) @(negedge clk);
    check("edge_stb_still", {31'h0, wb.wbm_stb_o}, 32'h1);
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h5A5A_0011;
    @(negedge clk);
    wb.wbm_ack_i = 1'b0;
    check("edge_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("edge_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("edge_rsp_rdata", rsp_rdata, 32'h5A5A_0011);
    rsp_handshake();

    // Response back-pressure with stray ack and a pending command
    send_cmd(1'b0, 32'h2400_0000, 32'h0, 4'hF);
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h0000_0077;
    @(negedge clk);
    wb.wbm_ack_i = 1'b0;
    cmd_valid    = 1'b1;
    cmd_we       = 1'b1;
    cmd_addr     = 32'h2500_0000;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0000_0077);
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("bp_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
      wb.wbm_ack_i = (i == 2);
      wb.wbm_dat_i = 32'h1111_1111;
      @(negedge clk);
    end
    wb.wbm_ack_i = 1'b0;
    check("bp_after_stray", rsp_rdata, 32'h0000_0077);
    check("bp_err", {31'h0, rsp_err}, 32'h0);
    // cmd_valid stays high across the handshake: nothing may start yet
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("hs_no_accept_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("hs_idle", {31'h0, cmd_ready}, 32'h1);
    check("hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset while strobe is high
    send_cmd(1'b1, 32'h2600_0000, 32'hCAFE_F00D, 4'hF);
    check("pre_rst_stb", {31'h0, wb.wbm_stb_o}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("async_rst_stb", {31'h0, wb.wbm_stb_o}, 32'h0);
    check("async_rst_adr", wb.wbm_adr_o, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);

    // First command after reset completes normally
    send_cmd(1'b0, 32'h2700_0020, 32'h0, 4'hC);
    check("post_rst_adr", wb.wbm_adr_o, 32'h2700_0020);
    check("post_rst_sel", {28'h0, wb.wbm_sel_o}, 32'hC);
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h1234_5678;
    @(negedge clk);
    wb.wbm_ack_i = 1'b0;
    check("post_rst_valid", {31'h0, rsp_valid}, 32'h1);
    check("post_rst_rdata", rsp_rdata, 32'h1234_5678);
    rsp_handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_master_bridge
